// File: rtl/pipe_scoreboard.sv
// rtl/pipe_scoreboard.sv - per-register latency scoreboard and RAW issue-stall generator at ID/EX
module pipe_scoreboard #(
  parameter int REG_COUNT = 32,
  parameter int REG_AW    = 5,
  parameter int MAX_LAT   = 4,
  parameter int LAT_W     = 3,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [REG_AW-1:0]    issue_rs,
  input  logic [REG_AW-1:0]    issue_rt,
  input  logic                 uses_rs,
  input  logic                 uses_rt,
  input  logic [REG_AW-1:0]    issue_rd,
  input  logic                 rd_we,
  input  logic [LAT_W-1:0]     issue_lat,
  input  logic                 hold,
  input  logic                 flush,
  output logic                 issue_fire,
  output logic                 stall,
  output logic [REG_COUNT-1:0] pending_mask,
  output logic                 busy,
  output logic [CNT_W-1:0]     stall_cycles
);

  localparam int CW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);

  logic [CW-1:0]        cnt_q [REG_COUNT];
  logic [CW-1:0]        cnt_d [REG_COUNT];
  logic [CNT_W-1:0]     stall_cycles_q, stall_cycles_d;
  logic [REG_COUNT-1:0] nz;
  logic                 rs_hit, rt_hit;
  logic                 do_write;
  logic [CW-1:0]        init_val;

  always_comb begin
    for (int r = 0; r < REG_COUNT; r++) begin
      nz[r] = (cnt_q[r] != '0);
    end
  end

  // Register 0 is skipped so it can never raise a hazard.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int r = 1; r < REG_COUNT; r++) begin
      if (issue_rs == REG_AW'(r) && nz[r]) rs_hit = 1'b1;
      if (issue_rt == REG_AW'(r) && nz[r]) rt_hit = 1'b1;
    end
  end

  assign stall      = issue_valid & ~flush & ((uses_rs & rs_hit) | (uses_rt & rt_hit));
  assign issue_fire = issue_valid & ~flush & ~hold & ~stall;
  assign do_write   = issue_fire & rd_we & (issue_rd != '0);

  // Out-of-range latencies are treated as the slowest unit.
  always_comb begin
    if (issue_lat == '0 || issue_lat > MAX_LAT_V) begin
      init_val = CW'(MAX_LAT - 1);
    end else begin
      init_val = CW'(issue_lat - LAT_W'(1));
    end
  end

  // Newest writer overrides the decrement of its entry.
  always_comb begin
    for (int r = 0; r < REG_COUNT; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!hold) begin
        if (nz[r]) cnt_d[r] = cnt_q[r] - CW'(1);
        if (do_write && issue_rd == REG_AW'(r)) cnt_d[r] = init_val;
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < REG_COUNT; r++) cnt_q[r] <= '0;
      stall_cycles_q <= '0;
    end else begin
      for (int r = 0; r < REG_COUNT; r++) cnt_q[r] <= cnt_d[r];
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign pending_mask = nz;
  assign busy         = |nz;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: doc/pipe_scoreboard.md
# pipe_scoreboard

Parametrised register scoreboard and issue-stall generator for the pipelined MIPS core. It sits at the ID→EX boundary. It tracks every in-flight register write whose result latency is 1..MAX_LAT cycles and stalls a dependent instruction until its operand can be forwarded. It generalises the fixed one-cycle load-use stall to any mix of multi-cycle units. It also provides a downstream hold, a flush input and a saturating stall-cycle counter for performance measurement.

## Interface
- REG_COUNT, default 32: number of architectural registers; register 0 is hard-wired zero.
- REG_AW, default 5: register index width; REG_COUNT ≤ 2^REG_AW.
- MAX_LAT, default 4: largest result latency in cycles; ≥ 1.
- LAT_W, default 3: width of `issue_lat`; must hold MAX_LAT.
- CNT_W, default 16: width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- issue_valid  in  1  instruction present at ID wants to issue.
- issue_rs, issue_rt  in  REG_AW  source register indices.
- uses_rs, uses_rt  in  1  the corresponding source is actually read.
- issue_rd  in  REG_AW  destination register index.
- rd_we  in  1  instruction writes `issue_rd`.
- issue_lat  in  LAT_W  result latency, 1..MAX_LAT.
- hold  in  1  downstream freeze (e.g. memory wait).
- flush  in  1  squash the instruction currently at ID.
- issue_fire  out  1  instruction issues this cycle.
- stall  out  1  RAW hazard blocks issue.
- pending_mask  out  REG_COUNT  bit r set when the counter for register r is nonzero.
- busy  out  1  OR of `pending_mask`.
- stall_cycles  out  CNT_W  saturating count of cycles with `stall` = 1.

## Operation
- State:
  - One down-counter `cnt[r]` per register, width clog2(MAX_LAT).
  - The `stall_cycles` register.
- Hazard detection (combinational):
  - `stall = issue_valid & !flush & ((uses_rs & cnt[issue_rs]≠0) | (uses_rt & cnt[issue_rt]≠0))`.
  - Register 0 never causes a hazard.
- Issue condition: `issue_fire = issue_valid & !flush & !hold & !stall`.
- Counter update each cycle when `hold` = 0:
  - Every nonzero `cnt[r]` decrements by 1.
  - If `issue_fire & rd_we & issue_rd≠0`, then `cnt[issue_rd] <= issue_lat-1`. This overrides the decrement of that entry, so the newest write wins (WAW).
  - Forwarding always selects the newest producer.
- Hold: when `hold` = 1, all counters freeze and `issue_fire` = 0. `stall` is still computed.
- Flush: the current ID instruction is not issued and does not update the scoreboard. Entries of already-issued instructions are unaffected.
- Latency semantics: a result with latency L can be consumed by an instruction issuing L cycles after the producer.
  - L = 1 (ALU): back-to-back issue, no stall.
  - L = 2 (load): one stall cycle.
- Illegal input: `issue_lat` = 0 or > MAX_LAT is treated as MAX_LAT.
- `stall_cycles`: increments when `stall` = 1 and saturates at 2^CNT_W-1.

## Timing
- Reset values (after the edge with `reset` = 1):
  - All `cnt` = 0.
  - `pending_mask` = 0, `busy` = 0, `stall_cycles` = 0.
  - `stall` = 0 and `issue_fire` = 0 unless driven by inputs.
- Reset mid-operation discards all pending entries on that edge.
- `stall` and `issue_fire` are combinational from the inputs and registered `cnt`. There is no extra latency.
- `pending_mask`, `busy` and `stall_cycles` are registered and reflect state after the last edge.
- Simultaneous issue and expiry: a reader of register r issues in the same cycle `cnt[r]` reads 0, even if a new writer of r also issues in that cycle. The new writer only affects the next cycle.
- An instruction that reads and writes the same register checks the old counter before its own update.
- `hold` and `flush` together: no issue and no update; counters frozen.

## Test plan
- Load-use, MAX_LAT = 4:
  - Cycle 0: issue `lw` with rd = 8, lat = 2.
  - Cycle 1: `add` reading rs = 8 gives `stall` = 1, `issue_fire` = 0.
  - Cycle 2: `issue_fire` = 1.
  - `stall_cycles` = 1.
- Back-to-back ALU: rd = 3 with lat = 1, then a reader of rs = 3 in the next cycle → no stall, `pending_mask` stays 0.
- Long latency with hold:
  - Issue rd = 5, lat = 4, then assert `hold` for 2 cycles.
  - A reader of 5 stalls through cycle 5 and issues in cycle 6.
  - `pending_mask[5]` = 1 through cycle 5.
- WAW and zero register:
  - Issue rd = 7 lat = 4, then rd = 7 lat = 1.
  - A reader of 7 in the next cycle issues with no stall.
  - Writes to rd = 0 with lat = 4 leave `pending_mask` = 0.
- Flush: `flush` = 1 with a pending writer of rd = 9, lat = 3 → `issue_fire` = 0 and `pending_mask[9]` stays 0.
- Reset mid-operation and saturation:
  - `reset` while `cnt[4]` = 2 → next cycle a reader of 4 issues.
  - With CNT_W = 2, a 5-cycle stall holds `stall_cycles` at 3.
